// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, exception and IO handshake.
// Optional IO watchdog enabled by defining PIPE_IO_TIMEOUT_EN.
module pipe_hazard_ctrl #(
    parameter int EXC_HOLD = 2
`ifdef PIPE_IO_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       mem_branch,
    input  logic       mem_equal,
    input  logic       mem_io_inst,
    input  logic       io_ready,
    input  logic       exc_req,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       ex_mem_hold,
    output logic [1:0] pc_sel,
    output logic       epc_write,
    output logic       io_req,
    output logic       exc_cause
);

    localparam int HW = $clog2(EXC_HOLD + 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_IO_WAIT   = 2'd1,
        ST_EXC_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [HW-1:0]   r_hold_cnt;
    logic            r_exc_pending;
    logic            r_io_done;
    logic            r_io_req;
    logic            w_exc_take;
    logic            w_io_take;
    logic            w_branch_take;
    logic            w_load_use;
    logic            w_timeout;

`ifdef PIPE_IO_TIMEOUT_EN
    logic [7:0]      r_to_cnt;
    logic            r_exc_cause;

    assign w_timeout = (r_state == ST_IO_WAIT) && !io_ready &&
                       (r_to_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign exc_cause = r_exc_cause & ~reset;
`else
    assign w_timeout = 1'b0;
    assign exc_cause = 1'b0;
`endif

    assign io_req = r_io_req;

    assign w_exc_take    = exc_req | r_exc_pending;
    assign w_io_take     = mem_io_inst & ~r_io_done;
    assign w_branch_take = mem_branch & mem_equal;
    assign w_load_use    = id_ex_memread && (id_ex_rt != 5'd0) &&
                           ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

    // NOTE: every output and the next state get a default first so no latch is inferred.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        ex_mem_hold  = 1'b0;
        pc_sel       = 2'b00;
        epc_write    = 1'b0;
        w_next_state = r_state;

        case (r_state)
            ST_RUN: begin
                if (w_exc_take) begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    epc_write    = 1'b1;
                    pc_sel       = 2'b10;
                    w_next_state = ST_EXC_FLUSH;
                end else if (w_io_take) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_flush  = 1'b1;
                    ex_mem_hold  = 1'b1;
                    w_next_state = ST_IO_WAIT;
                end else if (w_branch_take) begin
                    pc_sel       = 2'b01;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                end else if (w_load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_flush  = 1'b1;
                end
            end
            ST_IO_WAIT: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                ex_mem_hold = 1'b1;
                if (io_ready || w_timeout)
                    w_next_state = ST_RUN;
            end
            ST_EXC_FLUSH: begin
                pc_write     = 1'b0;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
                if (r_hold_cnt == HW'(1))
                    w_next_state = ST_RUN;
            end
            default: w_next_state = ST_RUN;
        endcase

        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            ex_mem_hold  = 1'b0;
            pc_sel       = 2'b00;
            epc_write    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_hold_cnt    <= '0;
            r_exc_pending <= 1'b0;
            r_io_done     <= 1'b0;
            r_io_req      <= 1'b0;
`ifdef PIPE_IO_TIMEOUT_EN
            r_to_cnt      <= 8'd0;
            r_exc_cause   <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_RUN: begin
                    // io_done only shields the single RUN cycle after completion
                    r_io_done <= 1'b0;
                    if (w_exc_take) begin
                        r_exc_pending <= 1'b0;
                        r_hold_cnt    <= HW'(EXC_HOLD);
`ifdef PIPE_IO_TIMEOUT_EN
                        r_exc_cause   <= 1'b0;
`endif
                    end else if (w_io_take) begin
                        r_io_req <= 1'b1;
`ifdef PIPE_IO_TIMEOUT_EN
                        r_to_cnt <= 8'd0;
`endif
                    end
                end
                ST_IO_WAIT: begin
                    if (exc_req)
                        r_exc_pending <= 1'b1;
`ifdef PIPE_IO_TIMEOUT_EN
                    r_to_cnt <= r_to_cnt + 8'd1;
`endif
                    if (io_ready) begin
                        r_io_req  <= 1'b0;
                        r_io_done <= 1'b1;
                    end else if (w_timeout) begin
                        r_io_req      <= 1'b0;
                        r_exc_pending <= 1'b1;
`ifdef PIPE_IO_TIMEOUT_EN
                        r_exc_cause   <= 1'b1;
`endif
                    end
                end
                ST_EXC_FLUSH: begin
                    if (exc_req)
                        r_exc_pending <= 1'b1;
                    r_hold_cnt <= r_hold_cnt - HW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// all compared each cycle against a cycle-counting behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int EXC_HOLD = 2;
    localparam int TIMEOUT  = 8;

    logic       clk = 1'b0;
    logic       reset, id_ex_memread, mem_branch, mem_equal, mem_io_inst, io_ready, exc_req;
    logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, ex_mem_hold;
    logic [1:0] pc_sel;
    logic       epc_write, io_req, exc_cause;

    int n_pass  = 0;
    int n_total = 0;

    // model state: remaining flush cycles, waiting on IO, pending exception, etc.
    int m_flush_left = 0;
    bit m_waiting    = 0;
    bit m_io_done    = 0;
    bit m_pending    = 0;
    bit m_io_req     = 0;
    bit m_cause      = 0;
    int m_wait_cycles = 0;

    always #5 clk = ~clk;

`ifdef PIPE_IO_TIMEOUT_EN
    pipe_hazard_ctrl #(.EXC_HOLD(EXC_HOLD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
`else
    pipe_hazard_ctrl #(.EXC_HOLD(EXC_HOLD)) dut (
`endif
        .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .mem_branch(mem_branch), .mem_equal(mem_equal),
        .mem_io_inst(mem_io_inst), .io_ready(io_ready), .exc_req(exc_req),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .ex_mem_hold(ex_mem_hold),
        .pc_sel(pc_sel), .epc_write(epc_write), .io_req(io_req), .exc_cause(exc_cause));

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp, input int cyc);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, got, exp);
    endtask

    task automatic step(input logic rst, input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] irt, input logic br, input logic eq, input logic io,
                        input logic rdy, input logic exc, input int cyc);
        bit e_pcw, e_ifw, e_iff, e_ief, e_emf, e_emh, e_epc;
        logic [1:0] e_sel;
        bit running, take_exc, take_io;
        @(negedge clk);
        reset = rst; id_ex_memread = mr; id_ex_rt = rt; if_id_rs = rs; if_id_rt = irt;
        mem_branch = br; mem_equal = eq; mem_io_inst = io; io_ready = rdy; exc_req = exc;
        #1;
        running  = (m_flush_left == 0) && !m_waiting;
        take_exc = running && (exc || m_pending);
        take_io  = running && !take_exc && io && !m_io_done;
        {e_pcw, e_ifw, e_iff, e_ief, e_emf, e_emh, e_epc} = 7'b1100000;
        e_sel = 2'b00;
        if (m_flush_left > 0) begin
            e_pcw = 0; e_iff = 1; e_ief = 1; e_emf = 1;
        end else if (m_waiting || take_io) begin
            e_pcw = 0; e_ifw = 0; e_ief = 1; e_emh = 1;
        end else if (take_exc) begin
            e_iff = 1; e_ief = 1; e_emf = 1; e_epc = 1; e_sel = 2'b10;
        end else if (br && eq) begin
            e_iff = 1; e_ief = 1; e_emf = 1; e_sel = 2'b01;
        end else if (mr && rt != 0 && (rt == rs || rt == irt)) begin
            e_pcw = 0; e_ifw = 0; e_ief = 1;
        end
        if (rst) begin
            {e_pcw, e_ifw, e_iff, e_ief, e_emf, e_emh, e_epc} = 7'b0;
            e_sel = 2'b00;
        end
        check("pc_write",     {1'b0, pc_write},     {1'b0, e_pcw},  cyc);
        check("if_id_write",  {1'b0, if_id_write},  {1'b0, e_ifw},  cyc);
        check("if_id_flush",  {1'b0, if_id_flush},  {1'b0, e_iff},  cyc);
        check("id_ex_flush",  {1'b0, id_ex_flush},  {1'b0, e_ief},  cyc);
        check("ex_mem_flush", {1'b0, ex_mem_flush}, {1'b0, e_emf},  cyc);
        check("ex_mem_hold",  {1'b0, ex_mem_hold},  {1'b0, e_emh},  cyc);
        check("pc_sel",       pc_sel,               e_sel,          cyc);
        check("epc_write",    {1'b0, epc_write},    {1'b0, e_epc},  cyc);
        check("io_req",       {1'b0, io_req},       {1'b0, m_io_req}, cyc);
        check("exc_cause",    {1'b0, exc_cause},    {1'b0, m_cause && !rst}, cyc);
        @(posedge clk);
        if (rst) begin
            m_flush_left = 0; m_waiting = 0; m_io_done = 0; m_pending = 0;
            m_io_req = 0; m_cause = 0; m_wait_cycles = 0;
        end else if (m_flush_left > 0) begin
            if (exc) m_pending = 1;
            m_flush_left--;
        end else if (m_waiting) begin
            m_wait_cycles++;
            if (exc) m_pending = 1;
            if (rdy) begin
                m_waiting = 0; m_io_req = 0; m_io_done = 1;
            end
`ifdef PIPE_IO_TIMEOUT_EN
            else if (m_wait_cycles == TIMEOUT) begin
                m_waiting = 0; m_io_req = 0; m_cause = 1; m_pending = 1;
            end
`endif
        end else begin
            m_io_done = 0;
            if (take_exc) begin
                m_pending = 0; m_flush_left = EXC_HOLD; m_cause = 0;
            end else if (take_io) begin
                m_waiting = 1; m_io_req = 1; m_wait_cycles = 0;
            end
        end
    endtask

    initial begin
        int cyc = 0;
        reset = 1; id_ex_memread = 0; id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
        mem_branch = 0; mem_equal = 0; mem_io_inst = 0; io_ready = 0; exc_req = 0;
        @(posedge clk);
        // reset held: all controls forced low
        step(1, 1, 5, 5, 0, 1, 1, 1, 0, 1, cyc++);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cyc++);
        // load-use hit on rs, hit on rt, then rt=0 (no stall)
        step(0, 1, 5, 5, 0, 0, 0, 0, 0, 0, cyc++);
        step(0, 1, 7, 1, 7, 0, 0, 0, 0, 0, cyc++);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, cyc++);
        // branch taken, then not taken
        step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, cyc++);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, cyc++);
        // IO with ack in the 4th wait cycle, then released without re-entry
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, cyc++);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, cyc++);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, cyc++);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, cyc++);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cyc++);
        // exception pulse, second pulse during flush goes pending
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, cyc++);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, cyc++);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cyc++);
        // exception during IO wait, ack and exception together
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, cyc++);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, cyc++);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, cyc++);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, cyc++);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cyc++);
        // long IO wait (watchdog fires when enabled), then late ack
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, cyc++);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, cyc++);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, cyc++);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cyc++);
        // reset in the middle of IO wait
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, cyc++);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, cyc++);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, cyc++);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cyc++);
        // random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) == 0, 1'($urandom), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0, cyc++);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
